// File: rtl/alu_mdu.sv
// Single-issue ALU with iterative radix-2 multiplier and optional restoring divider.
// Build option: define ALU_MDU_DIV_EN to include DIV/DIVU/REM/REMU, otherwise those ops report illegal.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic              neg_r;
    logic              hi_r;
    logic [2*XLEN-1:0] prod_r;
    logic [2*XLEN-1:0] mcand_r;
    logic [XLEN-1:0]   mplier_r;

    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   base_res_s;
    logic              base_ill_s;
    logic              short_s;
    logic [XLEN-1:0]   short_res_s;
    logic              short_ill_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [CW-1:0]     cnt_nxt_s;
    logic [2*XLEN-1:0] prod_nxt_s;
    logic [2*XLEN-1:0] mul_full_s;
    logic [XLEN-1:0]   fin_res_s;

`ifdef ALU_MDU_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic              is_div_r;
    logic              rem_sel_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   dvs_r;
    logic [XLEN:0]     sh_s;
    logic              ge_s;
    logic [XLEN-1:0]   rem_nxt_s;
    logic [XLEN-1:0]   quo_nxt_s;
    logic [XLEN-1:0]   div_val_s;
`endif

    // Base ALU operations, all single-cycle.
    always_comb begin
        shamt_s    = b[SHW-1:0];
        base_res_s = {XLEN{1'b0}};
        base_ill_s = 1'b0;
        case (op[3:0])
            4'b0000: base_res_s = a + b;
            4'b1000: base_res_s = a - b;
            4'b0010: base_res_s = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: base_res_s = {{(XLEN-1){1'b0}}, a < b};
            4'b0111: base_res_s = a & b;
            4'b0110: base_res_s = a | b;
            4'b0100: base_res_s = a ^ b;
            4'b0001: base_res_s = a << shamt_s;
            4'b0101: base_res_s = a >> shamt_s;
            4'b1101: base_res_s = $signed(a) >>> shamt_s;
            default: base_ill_s = 1'b1;
        endcase
    end

    // Ops that finish in one cycle: base ops, divide special cases, or unsupported divide.
    always_comb begin
        short_s     = 1'b0;
        short_res_s = {XLEN{1'b0}};
        short_ill_s = 1'b0;
        if (!op[4]) begin
            short_s     = 1'b1;
            short_res_s = base_res_s;
            short_ill_s = base_ill_s;
        end else if (op[2]) begin
`ifdef ALU_MDU_DIV_EN
            if (b == {XLEN{1'b0}}) begin
                short_s     = 1'b1;
                short_res_s = op[1] ? a : {XLEN{1'b1}};
            end else if (!op[0] && (a == MIN_NEG) && (b == {XLEN{1'b1}})) begin
                short_s     = 1'b1;
                short_res_s = op[1] ? {XLEN{1'b0}} : a;
            end else begin
                short_s     = 1'b0;
            end
`else
            short_s     = 1'b1;
            short_ill_s = 1'b1;
`endif
        end else begin
            short_s     = 1'b0;
        end
    end

    // Operand magnitudes: signed divide uses ~op[0]; MULH signs both, MULHSU signs only a.
    always_comb begin
        a_neg_s = a[XLEN-1] & (op[2] ? ~op[0] : (op[1] ^ op[0]));
        b_neg_s = b[XLEN-1] & (op[2] ? ~op[0] : (~op[1] & op[0]));
        a_mag_s = a_neg_s ? -a : a;
        b_mag_s = b_neg_s ? -b : b;
    end

    // One shift-add / restoring-subtract step, plus the sign-corrected final value.
    always_comb begin
        cnt_nxt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        prod_nxt_s = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
        mul_full_s = neg_r ? -prod_nxt_s : prod_nxt_s;
        fin_res_s  = hi_r ? mul_full_s[2*XLEN-1:XLEN] : mul_full_s[XLEN-1:0];
`ifdef ALU_MDU_DIV_EN
        sh_s       = {rem_r, quo_r[XLEN-1]};
        ge_s       = sh_s >= {1'b0, dvs_r};
        rem_nxt_s  = ge_s ? (sh_s[XLEN-1:0] - dvs_r) : sh_s[XLEN-1:0];
        quo_nxt_s  = {quo_r[XLEN-2:0], ge_s};
        div_val_s  = rem_sel_r ? rem_nxt_s : quo_nxt_s;
        if (is_div_r) begin
            fin_res_s = neg_r ? -div_val_s : div_val_s;
        end else begin
            fin_res_s = hi_r ? mul_full_s[2*XLEN-1:XLEN] : mul_full_s[XLEN-1:0];
        end
`endif
    end

    // Control FSM with registered handshake outputs and iterative datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= {XLEN{1'b0}};
            illegal   <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            neg_r     <= 1'b0;
            hi_r      <= 1'b0;
            prod_r    <= {(2*XLEN){1'b0}};
            mcand_r   <= {(2*XLEN){1'b0}};
            mplier_r  <= {XLEN{1'b0}};
`ifdef ALU_MDU_DIV_EN
            is_div_r  <= 1'b0;
            rem_sel_r <= 1'b0;
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (short_s) begin
                            result    <= short_res_s;
                            illegal   <= short_ill_s;
                            out_valid <= 1'b1;
                            state_r   <= S_DONE;
                        end else begin
                            cnt_r    <= {CW{1'b0}};
                            prod_r   <= {(2*XLEN){1'b0}};
                            mcand_r  <= {{XLEN{1'b0}}, a_mag_s};
                            mplier_r <= b_mag_s;
                            hi_r     <= (op[1:0] != 2'b00);
                            // Remainder follows the dividend's sign; everything else the product sign.
                            neg_r    <= (op[2] & op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
`ifdef ALU_MDU_DIV_EN
                            is_div_r  <= op[2];
                            rem_sel_r <= op[1];
                            rem_r     <= {XLEN{1'b0}};
                            quo_r     <= a_mag_s;
                            dvs_r     <= b_mag_s;
`endif
                            state_r  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_r    <= cnt_nxt_s;
                    prod_r   <= prod_nxt_s;
                    mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
                    rem_r    <= rem_nxt_s;
                    quo_r    <= quo_nxt_s;
`endif
                    if (cnt_nxt_s == CW'(XLEN)) begin
                        result    <= fin_res_s;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
